// File: rtl/hist_pkg.sv
// Shared definitions for the histogram-to-LUT builder: default geometry,
// FSM state encoding and the fixed-point scale helper.
package hist_pkg;

    localparam int unsigned DEF_IW     = 800;
    localparam int unsigned DEF_IH     = 600;
    localparam int unsigned DEF_BINS   = 256;
    localparam int unsigned DEF_LEVELS = 256;
    localparam int unsigned DEF_FRAC   = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT_DONE,
        S_REQ,
        S_DRAIN
    } state_t;

    // Rounded (LEVELS-1)/TOTAL in unsigned fixed point with FRAC fraction bits.
    function automatic logic [63:0] calc_scale(input longint unsigned total,
                                               input longint unsigned levels,
                                               input longint unsigned frac);
        return (((levels - 64'd1) << frac) + total / 64'd2) / total;
    endfunction

endpackage

// File: rtl/hist_cdf_scale.sv
// Three-stage pipeline: accumulate bin counts into a CDF, multiply by the
// fixed-point scale, then round and saturate into a gray-level mapping.
module hist_cdf_scale
    import hist_pkg::*;
#(
    parameter  int unsigned BINS   = DEF_BINS,
    parameter  int unsigned LEVELS = DEF_LEVELS,
    parameter  int unsigned FRAC   = DEF_FRAC,
    parameter  logic [63:0] SCALE  = 64'd1,
    localparam int unsigned AW     = $clog2(BINS),
    localparam int unsigned DW     = $clog2(LEVELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [31:0]   in_data,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic [31:0]   cdf,
    output logic [AW:0]   bin_cnt,
    output logic          empty
);

    localparam logic [63:0] HALF = 64'd1 << (FRAC - 1);
    localparam logic [63:0] VMAX = 64'(LEVELS - 1);

    logic          v1;
    logic          v2;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [63:0]   prod;
    logic [63:0]   rounded;

    always_comb begin
        rounded = (prod + HALF) >> FRAC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdf      <= '0;
            bin_cnt  <= '0;
            addr1    <= '0;
            addr2    <= '0;
            prod     <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            if (clear) begin
                cdf     <= '0;
                bin_cnt <= '0;
            end else if (in_vld && !flush) begin
                cdf     <= cdf + in_data;
                addr1   <= bin_cnt[AW-1:0];
                bin_cnt <= bin_cnt + 1'b1;
            end
            v1 <= in_vld && !flush && !clear;

            // cdf already holds the running sum for the bin sitting in stage 1
            if (v1) begin
                prod  <= {32'd0, cdf} * SCALE;
                addr2 <= addr1;
            end
            v2 <= v1 && !flush;

            out_vld <= v2 && !flush;
            if (v2) begin
                out_addr <= addr2;
                out_data <= (rounded > VMAX) ? DW'(VMAX) : rounded[DW-1:0];
            end
        end
    end

    assign empty = !v1 && !v2;

endmodule

// File: rtl/hist_lut_builder.sv
// Reads a finished histogram out of the statistics block with a read-then-clear
// request burst and writes the equalization mapping into the LUT RAM.
module hist_lut_builder
    import hist_pkg::*;
#(
    parameter  int unsigned IW     = DEF_IW,
    parameter  int unsigned IH     = DEF_IH,
    parameter  int unsigned BINS   = DEF_BINS,
    parameter  int unsigned LEVELS = DEF_LEVELS,
    parameter  int unsigned FRAC   = DEF_FRAC,
    localparam int unsigned AW     = $clog2(BINS),
    localparam int unsigned DW     = $clog2(LEVELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          flag_finish,
    input  logic [31:0]   hist_data,
    input  logic          hist_vld,
    output logic          out_req,
    output logic          lut_wr_en,
    output logic [AW-1:0] lut_wr_addr,
    output logic [DW-1:0] lut_wr_data,
    output logic          lut_done,
    output logic          busy,
    output logic [31:0]   cdf_total,
    output logic          sum_err,
    output logic          abort_err
);

    localparam int unsigned TOTAL   = IW * IH;
    localparam logic [63:0] SCALE   = calc_scale(TOTAL, LEVELS, FRAC);
    localparam int unsigned REQ_LEN = 2 * BINS;
    localparam int unsigned RW      = $clog2(REQ_LEN);
    localparam int unsigned WDOG    = 8;

    state_t        state;
    logic          flag_q;
    logic          flag_prev;
    logic          fall;
    logic          rise;
    logic [RW-1:0] req_cnt;
    logic [2:0]    drain_cnt;
    logic          in_busy;
    logic          accept;
    logic          extra;
    logic          drain_done;
    logic          abort;
    logic          clear;
    logic [31:0]   cdf;
    logic [AW:0]   bin_cnt;
    logic          empty;

    assign fall = flag_prev & ~flag_q;
    assign rise = ~flag_prev & flag_q;

    always_comb begin
        in_busy    = (state == S_REQ) || (state == S_DRAIN);
        accept     = hist_vld && in_busy && (bin_cnt < (AW+1)'(BINS));
        extra      = hist_vld && in_busy && (bin_cnt == (AW+1)'(BINS));
        drain_done = (state == S_DRAIN) && empty && (bin_cnt == (AW+1)'(BINS));
        // A restarted frame or an expired drain watchdog both discard the read-out
        abort      = (in_busy && fall) ||
                     ((state == S_DRAIN) && !drain_done && (drain_cnt == 3'(WDOG - 1)));
        clear      = (state == S_WAIT_DONE) && enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            flag_q    <= 1'b0;
            flag_prev <= 1'b0;
            req_cnt   <= '0;
            drain_cnt <= '0;
            out_req   <= 1'b0;
            busy      <= 1'b0;
            lut_done  <= 1'b0;
            cdf_total <= '0;
            sum_err   <= 1'b0;
            abort_err <= 1'b0;
        end else begin
            flag_q    <= flag_finish;
            flag_prev <= flag_q;
            lut_done  <= 1'b0;
            if (extra) begin
                sum_err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (rise) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (enable) begin
                        state   <= S_REQ;
                        out_req <= 1'b1;
                        busy    <= 1'b1;
                        req_cnt <= '0;
                    end else if (fall) begin
                        state <= S_ARMED;
                    end
                end
                S_REQ: begin
                    if (abort) begin
                        state     <= S_ARMED;
                        out_req   <= 1'b0;
                        busy      <= 1'b0;
                        abort_err <= 1'b1;
                    end else if (req_cnt == RW'(REQ_LEN - 1)) begin
                        state     <= S_DRAIN;
                        out_req   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state     <= S_ARMED;
                        busy      <= 1'b0;
                        abort_err <= 1'b1;
                    end else if (drain_done) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        lut_done  <= 1'b1;
                        cdf_total <= cdf;
                        if (cdf != 32'(TOTAL)) begin
                            sum_err <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    hist_cdf_scale #(
        .BINS   (BINS),
        .LEVELS (LEVELS),
        .FRAC   (FRAC),
        .SCALE  (SCALE)
    ) u_cdf_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .flush    (abort),
        .in_vld   (accept),
        .in_data  (hist_data),
        .out_vld  (lut_wr_en),
        .out_addr (lut_wr_addr),
        .out_data (lut_wr_data),
        .cdf      (cdf),
        .bin_cnt  (bin_cnt),
        .empty    (empty)
    );

endmodule
